imem_boot_ctrl: RTL and testbench

Boot sequencer for the instruction memory of `cpu_top`. It receives a framed byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words, which it writes into instruction memory through the `Inst_addr_load`/`Inst_load`/`load_en` port. It also controls the memory reset and the processor reset, so the core leaves reset only after a complete, checksum-verified image has been loaded.

---
 rtl/boot_pkg.sv | 34 +++
 rtl/byte_word_packer.sv | 36 +++
 rtl/imem_boot_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot sequencer: FSM states, error codes
// and small address/handshake helpers.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_MEM_CLR = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_DATA    = 3'd3,
        ST_CHK     = 3'd4,
        ST_WAIT    = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } boot_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;

    // States in which the byte stream is consumed.
    function automatic logic rx_open(input boot_state_e st);
        logic open_v;
        case (st)
            ST_HDR0, ST_HDR1, ST_DATA, ST_CHK: open_v = 1'b1;
            default:                           open_v = 1'b0;
        endcase
        return open_v;
    endfunction

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian 4-byte to 32-bit word assembler. The completed word and its strobe
// are presented in the same cycle as the 4th byte so the controller can register them.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] low_r;
    logic [1:0]  byte_idx_r;

    // Holds the three lower bytes of the word in flight and the byte position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_r      <= 24'd0;
            byte_idx_r <= 2'd0;
        end else if (clr) begin
            low_r      <= 24'd0;
            byte_idx_r <= 2'd0;
        end else if (byte_valid) begin
            low_r      <= {byte_data, low_r[23:8]};
            byte_idx_r <= byte_idx_r + 2'd1;
        end else begin
            low_r      <= low_r;
            byte_idx_r <= byte_idx_r;
        end
    end

    assign word      = {byte_data, low_r};
    assign word_done = byte_valid && (byte_idx_r == 2'd3);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: loads a framed, XOR-checked image into instruction memory and
// sequences the memory and core resets around it.
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int MEM_RST_CYCLES = 2,
    parameter int CPU_RST_DELAY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        boot_req,
    output logic [31:0] Inst_addr_load,
    output logic [31:0] Inst_load,
    output logic        load_en,
    output logic        rst_n_mem,
    output logic        rst_n_cpu,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    boot_state_e      state_r, state_nxt_s;
    logic [7:0]       cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0] word_idx_r;
    logic [15:0]      word_cnt_r;
    logic [7:0]       cnt_lo_r;
    logic [7:0]       acc_r;
    logic [1:0]       err_nxt_s;
    logic             accept_s;
    logic [15:0]      frame_len_s;
    logic [15:0]      next_word_s;
    logic [31:0]      word_s;
    logic             word_done_s;

    assign accept_s    = rx_valid && rx_ready;
    assign frame_len_s = {rx_data, cnt_lo_r};
    assign next_word_s = 16'(word_idx_r) + 16'd1;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_r == ST_MEM_CLR),
        .byte_valid (accept_s && (state_r == ST_DATA)),
        .byte_data  (rx_data),
        .word       (word_s),
        .word_done  (word_done_s)
    );

    // Next-state, error code and phase-counter selection.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err;
        case (state_r)
            ST_MEM_CLR: begin
                if (cnt_r == 8'(MEM_RST_CYCLES - 1)) state_nxt_s = ST_HDR0;
                else                                  state_nxt_s = ST_MEM_CLR;
            end
            ST_HDR0: begin
                if (accept_s) state_nxt_s = ST_HDR1;
                else          state_nxt_s = ST_HDR0;
            end
            ST_HDR1: begin
                if (!accept_s) begin
                    state_nxt_s = ST_HDR1;
                end else if (frame_len_s > 16'(DEPTH)) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_LEN;
                end else if (frame_len_s == 16'd0) begin
                    state_nxt_s = ST_CHK;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done_s && (next_word_s == word_cnt_r)) state_nxt_s = ST_CHK;
                else                                             state_nxt_s = ST_DATA;
            end
            ST_CHK: begin
                if (!accept_s) begin
                    state_nxt_s = ST_CHK;
                end else if (rx_data == acc_r) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_CHK;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'(CPU_RST_DELAY - 1)) state_nxt_s = ST_RUN;
                else                                 state_nxt_s = ST_WAIT;
            end
            ST_RUN, ST_ERROR: begin
                if (boot_req) begin
                    state_nxt_s = ST_MEM_CLR;
                    err_nxt_s   = ERR_NONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_MEM_CLR;
                err_nxt_s   = ERR_NONE;
            end
        endcase

        // The phase counter only runs while dwelling in a timed state.
        if ((state_nxt_s == state_r) && ((state_r == ST_MEM_CLR) || (state_r == ST_WAIT)))
            cnt_nxt_s = cnt_r + 8'd1;
        else
            cnt_nxt_s = 8'd0;
    end

    // FSM state plus frame bookkeeping: length, word index and running XOR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_MEM_CLR;
            cnt_r      <= 8'd0;
            word_idx_r <= '0;
            word_cnt_r <= 16'd0;
            cnt_lo_r   <= 8'd0;
            acc_r      <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (state_r == ST_MEM_CLR) begin
                word_idx_r <= '0;
                word_cnt_r <= 16'd0;
                cnt_lo_r   <= 8'd0;
                acc_r      <= 8'd0;
            end else if (accept_s) begin
                acc_r <= acc_r ^ rx_data;
                if (state_r == ST_HDR0) cnt_lo_r <= rx_data;
                else                    cnt_lo_r <= cnt_lo_r;
                if (state_r == ST_HDR1) word_cnt_r <= frame_len_s;
                else                    word_cnt_r <= word_cnt_r;
                if (word_done_s) word_idx_r <= word_idx_r + IDX_W'(1);
                else             word_idx_r <= word_idx_r;
            end else begin
                word_idx_r <= word_idx_r;
                word_cnt_r <= word_cnt_r;
                cnt_lo_r   <= cnt_lo_r;
                acc_r      <= acc_r;
            end
        end
    end

    // Registered outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready       <= 1'b0;
            rst_n_mem      <= 1'b0;
            rst_n_cpu      <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= ERR_NONE;
            load_en        <= 1'b0;
            Inst_addr_load <= 32'd0;
            Inst_load      <= 32'd0;
        end else begin
            rx_ready  <= rx_open(state_nxt_s);
            rst_n_mem <= (state_nxt_s != ST_MEM_CLR);
            rst_n_cpu <= (state_nxt_s == ST_RUN);
            busy      <= (state_nxt_s != ST_RUN) && (state_nxt_s != ST_ERROR);
            done      <= (state_nxt_s == ST_RUN);
            err       <= err_nxt_s;
            load_en   <= word_done_s;
            if (word_done_s) begin
                Inst_addr_load <= word_addr(16'(word_idx_r));
                Inst_load      <= word_s;
            end else begin
                Inst_addr_load <= Inst_addr_load;
                Inst_load      <= Inst_load;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: random frames against a frame-level
// reference model, plus directed length, checksum, reload and mid-stream reset cases.
module tb_imem_boot_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        boot_req = 1'b0;
    logic [31:0] Inst_addr_load;
    logic [31:0] Inst_load;
    logic        load_en;
    logic        rst_n_mem;
    logic        rst_n_cpu;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    imem_boot_ctrl #(.DEPTH(DEPTH), .MEM_RST_CYCLES(2), .CPU_RST_DELAY(2)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .boot_req(boot_req), .Inst_addr_load(Inst_addr_load), .Inst_load(Inst_load),
        .load_en(load_en), .rst_n_mem(rst_n_mem), .rst_n_cpu(rst_n_cpu),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int chk_cyc = 0;
    int rel_cyc = -1;
    logic prev_cpu = 1'b0;

    logic [7:0]  frame_q[$];
    logic [31:0] words_q[$];
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [1:0]  exp_err;
    logic        exp_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write and release monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (load_en === 1'b1) got_q.push_back({Inst_addr_load, Inst_load});
        if (rst_n_cpu === 1'b1 && prev_cpu === 1'b0) rel_cyc = cyc;
        prev_cpu = rst_n_cpu;
    end

    // Frame builder: header-only when the count is out of range.
    task automatic build(input int n, input bit bad);
        logic [7:0] x;
        frame_q = {};
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++) frame_q.push_back(8'(words_q[i] >> (8 * b)));
            x = 8'd0;
            foreach (frame_q[i]) x = x ^ frame_q[i];
            frame_q.push_back(bad ? (x ^ 8'h5A) : x);
        end
    endtask

    // Reference model: parse the frame and derive writes and final status.
    task automatic predict();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q = {};
        n = int'({frame_q[1], frame_q[0]});
        if (n > DEPTH) begin
            exp_err  = 2'd1;
            exp_done = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = {frame_q[2+4*i+3], frame_q[2+4*i+2], frame_q[2+4*i+1], frame_q[2+4*i]};
                exp_q.push_back({32'(i * 4), w});
            end
            x = 8'd0;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame_q[i];
            exp_err  = (frame_q[2+4*n] == x) ? 2'd0 : 2'd2;
            exp_done = (exp_err == 2'd0);
        end
    endtask

    // Byte source; mode 0 back-to-back, 1 alternate cycles, 2 random gaps.
    task automatic drive(input int mode, input int abort_at);
        int idx = 0;
        int budget = 0;
        bit tog = 1'b0;
        logic v;
        while (idx < frame_q.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (idx == abort_at) begin
                rx_valid = 1'b1;
                rx_data  = frame_q[idx];
                rst      = 1'b1;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            rx_valid = v;
            rx_data  = v ? frame_q[idx] : 8'($urandom);
            if (v && rx_ready) begin
                if (idx == frame_q.size() - 1) chk_cyc = cyc;
                idx++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("drv_bytes", 64'(idx), 64'(frame_q.size()));
    endtask

    task automatic run_frame(input int n, input bit bad, input int mode, input string tag);
        got_q   = {};
        rel_cyc = -1;
        build(n, bad);
        predict();
        drive(mode, -1);
        repeat (8) @(negedge clk);
        check_eq({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
        check_eq({tag, "_done"}, 64'(done), 64'(exp_done));
        check_eq({tag, "_rst_n_cpu"}, 64'(rst_n_cpu), 64'(exp_done));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        if (exp_done) check_eq({tag, "_rel_lat"}, 64'(rel_cyc - chk_cyc), 64'd3);
    endtask

    task automatic reboot(input string tag);
        int low = 0;
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        check_eq({tag, "_req_state"}, {61'd0, rst_n_cpu, done, busy}, {61'd0, 1'b0, 1'b0, 1'b1});
        check_eq({tag, "_req_err"}, 64'(err), 64'd0);
        for (int i = 0; i < 20 && rst_n_mem !== 1'b1; i++) begin
            low++;
            @(negedge clk);
        end
        check_eq({tag, "_mem_low"}, 64'(low), 64'd2);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr_data"}, {Inst_addr_load, Inst_load}, 64'd0);
        check_eq({tag, "_flags"}, {56'd0, rst_n_mem, rst_n_cpu, load_en, rx_ready, busy, done, err},
                 {56'd0, 8'b0000_1000});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        words_q = '{32'h00500093, 32'h00108113};
        run_frame(2, 1'b0, 0, "two_words");

        reboot("rb1");
        words_q = '{32'hDEADBEEF};
        run_frame(1, 1'b0, 0, "deadbeef");

        reboot("rb2");
        words_q = '{32'h00500093, 32'h00108113};
        run_frame(2, 1'b0, 1, "toggled");

        reboot("rb3");
        run_frame(300, 1'b0, 0, "len300");

        reboot("rb4");
        words_q = '{32'h12345678};
        run_frame(1, 1'b1, 0, "badchk");

        reboot("rb5");
        run_frame(0, 1'b0, 2, "empty");

        reboot("rb6");
        run_frame(DEPTH + 1, 1'b0, 0, "len257");

        reboot("rb7");
        words_q = {};
        for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom);
        run_frame(DEPTH, 1'b0, 0, "full");

        for (int f = 0; f < 12; f++) begin
            reboot($sformatf("rnd%0d_rb", f));
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 65535))
                                            : int'($urandom_range(0, 8));
            words_q = {};
            for (int i = 0; i < 8; i++) words_q.push_back($urandom);
            run_frame(n, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                      $sformatf("rnd%0d", f));
        end

        // Reset while the third data byte is on the bus, then a clean reload.
        reboot("rb_mid");
        words_q = '{32'hCAFEF00D, 32'h0BADC0DE};
        build(2, 1'b0);
        drive(0, 4);
        #1;
        check_reset_vals("midrst");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame(2, 1'b0, 2, "reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
